// File: rtl/word_narrow_pkg.sv
// Shared constants for the 32->16 narrowing unit: FSM encodings and signed
// 16-bit saturation limits.
package word_narrow_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

    localparam logic [15:0] SAT_MAX16 = 16'h7FFF;
    localparam logic [15:0] SAT_MIN16 = 16'h8000;

endpackage

// File: rtl/word_narrow_sat.sv
// Combinational signed range check of a 2*OUT_W word against signed OUT_W,
// with optional clamp to the signed min/max on overflow.
module word_narrow_sat #(
    parameter int OUT_W = 16
) (
    input  logic [2*OUT_W-1:0] word,
    input  logic               sat,
    output logic [OUT_W-1:0]   data,
    output logic               ovf
);

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W:0] upper;

    // Representable only when every bit from the narrow sign bit upward agrees.
    always_comb begin
        upper = word[2*OUT_W-1:OUT_W-1];
        ovf   = ~((&upper) | (~|upper));
        data  = word[OUT_W-1:0];
        if (ovf && sat) begin
            data = word[2*OUT_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/word_narrow.sv
// Streaming 32->16 narrowing unit: narrow mode emits one range-checked
// halfword per word, split mode emits both halves over two beats.
module word_narrow
    import word_narrow_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*OUT_W-1:0] in_data,
    input  logic               in_split,
    input  logic               in_sat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_ovf,
    output logic               out_last
);

    logic [1:0]         state;
    logic [OUT_W-1:0]   second_half;
    logic [OUT_W-1:0]   sat_data;
    logic               sat_ovf;
    logic               in_xfer;
    logic               out_xfer;

    word_narrow_sat #(.OUT_W(OUT_W)) u_sat (
        .word (in_data),
        .sat  (in_sat),
        .data (sat_data),
        .ovf  (sat_ovf)
    );

    assign out_valid = (state != ST_IDLE);
    assign in_ready  = (state == ST_IDLE) | (out_valid & out_ready & out_last);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // A new word always wins: in_ready only opens when the current word is
    // finished, so acceptance can overwrite the output registers directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            second_half <= '0;
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_last    <= 1'b0;
        end else if (in_xfer) begin
            state <= ST_BEAT0;
            if (in_split) begin
                out_data    <= LOW_FIRST ? in_data[OUT_W-1:0] : in_data[2*OUT_W-1:OUT_W];
                second_half <= LOW_FIRST ? in_data[2*OUT_W-1:OUT_W] : in_data[OUT_W-1:0];
                out_ovf     <= 1'b0;
                out_last    <= 1'b0;
            end else begin
                out_data <= sat_data;
                out_ovf  <= sat_ovf;
                out_last <= 1'b1;
            end
        end else if (out_xfer) begin
            if (state == ST_BEAT0 && !out_last) begin
                state    <= ST_BEAT1;
                out_data <= second_half;
                out_ovf  <= 1'b0;
                out_last <= 1'b1;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule
